// File: rtl/hdmi_island_sched.sv
// hdmi_island_sched: schedules the packet type of each HDMI data-island slot
// and buffers audio samples for the audio slots (0 and 1).
// Optional build macro: HDMI_AUDIO_STATS_EN adds underrun/overrun counters
// and the stats_clr input.
module hdmi_island_sched #(
  parameter int unsigned AW      = 4,
  parameter int unsigned LINES   = 45,
  parameter int unsigned CSB_LEN = 192
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          audio_w,
  input  logic [31:0]   audio,
  input  logic          slot_req,
  input  logic [1:0]    slot_idx,
  output logic          rsp_valid,
  output logic [2:0]    rsp_type,
  output logic [31:0]   rsp_sample,
  output logic          rsp_first,
  output logic [7:0]    rsp_csb,
  output logic [AW:0]   fifo_level,
  output logic          ovf
`ifdef HDMI_AUDIO_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   underrun_cnt,
  output logic [15:0]   overrun_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned YW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned CW    = 8;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [AW:0]     wptr_q, rptr_q, wptr_d, rptr_d;
  logic [YW-1:0]   y_q;
  logic            hs_q;
  logic [CW-1:0]   csb_q;
  logic            running, audio_slot, empty, full;
  logic            pop, push, drop, hs_rise;
  logic [2:0]      island_type, type_d;

  // Run state register: idle until the first vsync after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a vsync while idle starts the block for good
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (vsync) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO control, hsync edge and response type decode
  always_comb begin
    running     = (state_q == ST_RUN);
    audio_slot  = (slot_idx < 2'd2);
    empty       = (fifo_level == '0);
    full        = (fifo_level == (AW+1)'(DEPTH));
    pop         = slot_req && running && audio_slot && !empty;
    push        = audio_w && running && (!full || pop);
    drop        = audio_w && running && full && !pop;
    hs_rise     = hsync && !hs_q;
    wptr_d      = wptr_q + (AW+1)'(push);
    rptr_d      = rptr_q + (AW+1)'(pop);
    island_type = 3'd0;
    case (y_q)
      YW'(0):  island_type = 3'd2;
      YW'(1):  island_type = 3'd3;
      YW'(2):  island_type = 3'd4;
      YW'(3):  island_type = 3'd5;
      default: island_type = 3'd0;
    endcase
    type_d = 3'd0;
    if (running) begin
      if (audio_slot) type_d = empty ? 3'd0 : 3'd1;
      else            type_d = island_type;
    end
  end

  // Sample storage; the head read for a pop sees the pre-write contents
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= audio;
  end

  // Pointers, line counter, channel-status counter and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
      hs_q       <= 1'b0;
      y_q        <= '0;
      csb_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_type   <= '0;
      rsp_sample <= '0;
      rsp_first  <= 1'b0;
      rsp_csb    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_level <= wptr_d - rptr_d;
      if (drop) ovf <= 1'b1;
      hs_q <= hsync;
      if (hs_rise) y_q <= (y_q == YW'(LINES - 1)) ? '0 : y_q + YW'(1);
      if (pop) csb_q <= (csb_q == CW'(CSB_LEN - 1)) ? '0 : csb_q + CW'(1);
      rsp_valid <= slot_req;
      if (slot_req) begin
        rsp_type   <= type_d;
        rsp_sample <= pop ? mem[rptr_q[AW-1:0]] : '0;
        rsp_first  <= pop && (csb_q == '0);
        rsp_csb    <= pop ? csb_q : '0;
      end
    end
  end

`ifdef HDMI_AUDIO_STATS_EN
  // Saturating underrun/overrun counters; clear wins over increments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else if (stats_clr) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (slot_req && running && audio_slot && empty && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
      if (drop && (overrun_cnt != 16'hFFFF))
        overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_island_sched.sv
// Scoreboard bench for hdmi_island_sched: a reference model predicts each
// slot response when the request is driven; the response is compared when
// it appears one cycle later.
module tb_hdmi_island_sched;

  typedef struct packed {
    logic        v;
    logic [2:0]  t;
    logic [31:0] s;
    logic        f;
    logic [7:0]  c;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync, audio_w, slot_req;
  logic [31:0] audio;
  logic [1:0]  slot_idx;
  logic        rsp_valid, rsp_first, ovf;
  logic [2:0]  rsp_type;
  logic [31:0] rsp_sample;
  logic [7:0]  rsp_csb;
  logic [4:0]  fifo_level;
`ifdef HDMI_AUDIO_STATS_EN
  logic        stats_clr;
  logic [15:0] underrun_cnt, overrun_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_fifo[$];
  rsp_t        sbq[$];
  int          m_y, m_csb, m_under, m_over;
  bit          m_run, m_hs, m_ovf;

  hdmi_island_sched dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .audio_w(audio_w), .audio(audio), .slot_req(slot_req), .slot_idx(slot_idx),
    .rsp_valid(rsp_valid), .rsp_type(rsp_type), .rsp_sample(rsp_sample),
    .rsp_first(rsp_first), .rsp_csb(rsp_csb), .fifo_level(fifo_level), .ovf(ovf)
`ifdef HDMI_AUDIO_STATS_EN
    , .stats_clr(stats_clr), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_fifo.delete();
    sbq.delete();
    m_y = 0; m_csb = 0; m_under = 0; m_over = 0;
    m_run = 0; m_hs = 0; m_ovf = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, queue any expected response
  task automatic cycle(input logic w, input logic [31:0] d, input logic rq,
                       input logic [1:0] idx, input logic hs, input logic vs,
                       input logic clr);
    rsp_t e;
    bit popped;
    audio_w = w; audio = d; slot_req = rq; slot_idx = idx; hsync = hs; vsync = vs;
`ifdef HDMI_AUDIO_STATS_EN
    stats_clr = clr;
`endif
    popped = 0;
    e = '0;
    e.v = 1'b1;
    if (rq) begin
      if (!m_run) e.t = 3'd0;
      else if (idx < 2) begin
        if (m_fifo.size() == 0) begin
          if (m_under < 65535) m_under++;
        end else begin
          e.t = 3'd1;
          e.s = m_fifo.pop_front();
          e.c = 8'(m_csb);
          e.f = (m_csb == 0);
          m_csb = (m_csb == 191) ? 0 : m_csb + 1;
          popped = 1;
        end
      end else begin
        case (m_y)
          0: e.t = 3'd2;
          1: e.t = 3'd3;
          2: e.t = 3'd4;
          3: e.t = 3'd5;
          default: e.t = 3'd0;
        endcase
      end
      sbq.push_back(e);
    end
    if (w && m_run) begin
      if (m_fifo.size() < 16 || popped) m_fifo.push_back(d);
      else begin
        m_ovf = 1;
        if (m_over < 65535) m_over++;
      end
    end
    if (hs && !m_hs) m_y = (m_y == 44) ? 0 : m_y + 1;
    m_hs = hs;
    if (vs) m_run = 1;
    if (clr) begin m_under = 0; m_over = 0; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rsp_t e, o;
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0);
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== '0 || fifo_level !== 5'd0 || ovf !== 1'b0)
      $display("FAIL reset_outputs got rsp=%h lvl=%0d ovf=%b exp all 0", o, fifo_level, ovf);
    else n_pass++;
    reset = 1'b0;
    model_reset();
    // Not running: request answers null, write ignored
    cycle(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
    e = sbq.pop_front();
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== e) $display("FAIL idle_req got %h exp %h", o, e);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 5'(m_fifo.size())) $display("FAIL idle_write got lvl=%0d exp %0d", fifo_level, m_fifo.size());
    else n_pass++;
  endtask

  task automatic test_audio_basic();
    rsp_t e, o, last;
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h0002_0001, 0, 0, 0, 0, 0);
    cycle(1, 32'h0004_0003, 0, 0, 0, 0, 0);
    cycle(1, 32'h0006_0005, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 2'(i), 0, 0, 0);
      e = sbq.pop_front();
      o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
      n_checks++;
      if (o !== e) $display("FAIL audio_slot%0d got %h exp %h", i, o, e);
      else n_pass++;
      last = e;
    end
    n_checks++;
    if (fifo_level !== 5'd1) $display("FAIL basic_level got %0d exp 1", fifo_level);
    else n_pass++;
    // Idle cycle: strobe drops, payload holds
    cycle(0, 0, 0, 0, 0, 0, 0);
    last.v = 1'b0;
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== last) $display("FAIL rsp_hold got %h exp %h", o, last);
    else n_pass++;
    // Last sample, then an empty-FIFO request
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0);
      e = sbq.pop_front();
      o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
      n_checks++;
      if (o !== e) $display("FAIL drain_%0d got %h exp %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_island_rotation();
    rsp_t e, o;
    // Request in the same cycle as the hsync edge sees the pre-edge line
    for (int i = 0; i < 46; i++) begin
      cycle(0, 0, 1, (i == 2) ? 2'd3 : 2'd2, 1, 0, 0);
      e = sbq.pop_front();
      o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
      n_checks++;
      if (o !== e) $display("FAIL island_line%0d got %h exp %h", i, o, e);
      else n_pass++;
      cycle(0, 0, 0, 0, 0, 0, 0);
    end
    cycle(0, 0, 1, 2, 0, 0, 0);
    e = sbq.pop_front();
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== e) $display("FAIL island_after_wrap got %h exp %h", o, e);
    else n_pass++;
  endtask

  task automatic test_overflow();
    rsp_t e, o;
    for (int i = 0; i < 17; i++) cycle(1, 32'hA000_0000 + 32'(i), 0, 0, 0, 0, 0);
    n_checks++;
    if (fifo_level !== 5'd16 || ovf !== 1'b1 || m_ovf != 1)
      $display("FAIL ovf_fill got lvl=%0d ovf=%b exp lvl=16 ovf=1", fifo_level, ovf);
    else n_pass++;
    // Full FIFO: same-cycle pop makes room for the write
    cycle(1, 32'hB000_0000, 1, 0, 0, 0, 0);
    e = sbq.pop_front();
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== e) $display("FAIL full_pop got %h exp %h", o, e);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 5'd16 || fifo_level !== 5'(m_fifo.size()))
      $display("FAIL full_push_pop_level got %0d exp 16", fifo_level);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    rsp_t e, o;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 2'(i % 2), 0, 0, 0);
      e = sbq.pop_front();
      o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
      n_checks++;
      if (o !== e) $display("FAIL b2b_%0d got %h exp %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (fifo_level !== 5'd0) $display("FAIL b2b_level got %0d exp 0", fifo_level);
    else n_pass++;
  endtask

  task automatic test_midreset();
    rsp_t e, o;
    for (int i = 0; i < 5; i++) cycle(1, 32'hC000_0000 + 32'(i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 45 && m_y != 10; i++) begin
      cycle(0, 0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (fifo_level !== 5'd5 || m_y != 10) $display("FAIL pre_reset got lvl=%0d y=%0d exp 5/10", fifo_level, m_y);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== '0 || fifo_level !== 5'd0 || ovf !== 1'b0)
      $display("FAIL async_reset got rsp=%h lvl=%0d ovf=%b exp all 0", o, fifo_level, ovf);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1, 32'h1111_1111, 0, 0, 0, 0, 0);
    cycle(1, 32'h2222_2222, 0, 0, 0, 0, 0);
    n_checks++;
    if (fifo_level !== 5'd0) $display("FAIL write_before_vsync got lvl=%0d exp 0", fifo_level);
    else n_pass++;
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 0, 0, 0);
    e = sbq.pop_front();
    o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
    n_checks++;
    if (o !== e || rsp_type !== 3'd3) $display("FAIL post_reset_line1 got %h exp %h", o, e);
    else n_pass++;
  endtask

  task automatic test_csb_wrap();
    rsp_t e, o;
    cycle(1, $urandom, 0, 0, 0, 0, 0);
    for (int i = 0; i < 193; i++) begin
      cycle(1, $urandom, 1, 2'(i % 2), 0, 0, 0);
      e = sbq.pop_front();
      o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
      n_checks++;
      if (o !== e || (i == 192 && (rsp_csb !== 8'd0 || rsp_first !== 1'b1)))
        $display("FAIL csb_%0d got %h exp %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_stats();
`ifdef HDMI_AUDIO_STATS_EN
    rsp_t e, o;
    cycle(0, 0, 1, 0, 0, 0, 0);
    void'(sbq.pop_front());
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0);
      e = sbq.pop_front();
      o = {rsp_valid, rsp_type, rsp_sample, rsp_first, rsp_csb};
      n_checks++;
      if (o !== e || rsp_type !== 3'd0) $display("FAIL underrun_rsp%0d got %h exp %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (underrun_cnt !== 16'(m_under) || underrun_cnt !== 16'd3)
      $display("FAIL underrun_cnt got %0d exp 3", underrun_cnt);
    else n_pass++;
    cycle(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (underrun_cnt !== 16'd0) $display("FAIL underrun_clr got %0d exp 0", underrun_cnt);
    else n_pass++;
    for (int i = 0; i < 18; i++) cycle(1, 32'(i), 0, 0, 0, 0, 0);
    n_checks++;
    if (overrun_cnt !== 16'(m_over) || overrun_cnt !== 16'd2)
      $display("FAIL overrun_cnt got %0d exp 2", overrun_cnt);
    else n_pass++;
    // Clear in the same cycle as a drop: clear wins
    cycle(1, 32'h5, 0, 0, 0, 0, 1);
    n_checks++;
    if (overrun_cnt !== 16'd0 || overrun_cnt !== 16'(m_over))
      $display("FAIL overrun_clr got %0d exp 0", overrun_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b1; hsync = 0; vsync = 0; audio_w = 0; audio = 0; slot_req = 0; slot_idx = 0;
`ifdef HDMI_AUDIO_STATS_EN
    stats_clr = 0;
`endif
    model_reset();
    test_reset();
    test_audio_basic();
    test_island_rotation();
    test_overflow();
    test_back_to_back();
    test_midreset();
    test_csb_wrap();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
